// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Request/response bundle between two ALU clients and alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_lock;
   logic [WIDTH-1:0] req_a0;
   logic [WIDTH-1:0] req_b0;
   logic [WIDTH-1:0] req_a1;
   logic [WIDTH-1:0] req_b1;
   logic [2:0]       req_cmd0;
   logic [2:0]       req_cmd1;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_overflow;
   logic             rsp_carryout;

   modport master (
      output req_valid, req_lock, req_a0, req_b0, req_a1, req_b1,
             req_cmd0, req_cmd1, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero,
             rsp_overflow, rsp_carryout
   );

   modport slave (
      input  req_valid, req_lock, req_a0, req_b0, req_a1, req_b1,
             req_cmd0, req_cmd1, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero,
             rsp_overflow, rsp_carryout
   );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter (with combinational alu)
// Purpose  : Round-robin share of one ALU between two requesters, registered
//            response slot tagged with requester ID. Optional grant locking
//            is compiled in with `define ALU_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       cmd_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             overflow_o,
   output logic             carryout_o
);
   localparam logic [2:0] CMD_ADD  = 3'b000;
   localparam logic [2:0] CMD_SUB  = 3'b001;
   localparam logic [2:0] CMD_XOR  = 3'b010;
   localparam logic [2:0] CMD_SLT  = 3'b011;
   localparam logic [2:0] CMD_AND  = 3'b100;
   localparam logic [2:0] CMD_NAND = 3'b101;
   localparam logic [2:0] CMD_NOR  = 3'b110;
   localparam logic [2:0] CMD_OR   = 3'b111;

   logic             is_sub;
   logic             is_arith;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;

   // Subtraction is a + ~b + 1, so carryout means "no borrow".
   assign is_sub   = (cmd_i == CMD_SUB);
   assign is_arith = (cmd_i == CMD_ADD) || is_sub;
   assign b_eff    = is_sub ? ~b_i : b_i;
   assign sum      = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

   always_comb begin
      result_o = sum[WIDTH-1:0];
      case (cmd_i)
         CMD_XOR:  result_o = a_i ^ b_i;
         CMD_SLT: begin
            result_o    = '0;
            result_o[0] = ($signed(a_i) < $signed(b_i));
         end
         CMD_AND:  result_o = a_i & b_i;
         CMD_NAND: result_o = ~(a_i & b_i);
         CMD_NOR:  result_o = ~(a_i | b_i);
         CMD_OR:   result_o = a_i | b_i;
         default:  result_o = sum[WIDTH-1:0];
      endcase
   end

   assign zero_o     = is_arith && (sum[WIDTH-1:0] == '0);
   assign carryout_o = is_arith && sum[WIDTH];
   assign overflow_o = is_arith && (a_i[WIDTH-1] == b_eff[WIDTH-1])
                                && (sum[WIDTH-1] != a_i[WIDTH-1]);
endmodule

module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);
   localparam logic [0:0] SLOT_EMPTY = 1'b0;
   localparam logic [0:0] SLOT_FULL  = 1'b1;

   logic [0:0]       slot_q, slot_d;
   logic             last_q, last_d;
   logic             rsp_id_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q, ovf_q, cout_q;

   logic [1:0]       eligible;
   logic [1:0]       grant;
   logic             gid;
   logic             can_push;
   logic             push;

   logic [WIDTH-1:0] alu_a, alu_b, alu_res;
   logic [2:0]       alu_cmd;
   logic             alu_zero, alu_ovf, alu_cout;

`ifdef ALU_ARB_LOCK_EN
   logic own_q, own_d;
   logic own_id_q, own_id_d;

   always_comb begin
      eligible = bus.req_valid;
      if (own_q) eligible = bus.req_valid & (own_id_q ? 2'b10 : 2'b01);
   end

   // Ownership ends on an unlocked transfer, or when the owner goes idle
   // while nothing of its sequence is still waiting in the slot.
   always_comb begin
      own_d    = own_q;
      own_id_d = own_id_q;
      if (push) begin
         own_d    = bus.req_lock[gid];
         own_id_d = gid;
      end else if (own_q && !bus.req_valid[own_id_q] && (slot_q == SLOT_EMPTY)) begin
         own_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own_q    <= 1'b0;
         own_id_q <= 1'b0;
      end else begin
         own_q    <= own_d;
         own_id_q <= own_id_d;
      end
   end
`else
   assign eligible = bus.req_valid;
`endif

   always_comb begin
      grant = 2'b00;
      case (eligible)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign gid           = grant[1];
   assign can_push      = (slot_q == SLOT_EMPTY) || bus.rsp_ready;
   assign push          = (|grant) && can_push;
   assign bus.req_ready = grant & {2{can_push}};

   assign alu_a   = gid ? bus.req_a1   : bus.req_a0;
   assign alu_b   = gid ? bus.req_b1   : bus.req_b0;
   assign alu_cmd = gid ? bus.req_cmd1 : bus.req_cmd0;

   alu #(.WIDTH(WIDTH)) u_alu (
      .a_i        (alu_a),
      .b_i        (alu_b),
      .cmd_i      (alu_cmd),
      .result_o   (alu_res),
      .zero_o     (alu_zero),
      .overflow_o (alu_ovf),
      .carryout_o (alu_cout)
   );

   always_comb begin
      slot_d = slot_q;
      last_d = last_q;
      if (push) begin
         slot_d = SLOT_FULL;
         last_d = gid;
      end else if (bus.rsp_ready) begin
         slot_d = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q   <= SLOT_EMPTY;
         last_q   <= 1'b1;
         rsp_id_q <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         slot_q <= slot_d;
         last_q <= last_d;
         if (push) begin
            rsp_id_q <= gid;
            result_q <= alu_res;
            zero_q   <= alu_zero;
            ovf_q    <= alu_ovf;
            cout_q   <= alu_cout;
         end
      end
   end

   assign bus.rsp_valid    = (slot_q == SLOT_FULL);
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_result   = result_q;
   assign bus.rsp_zero     = zero_q;
   assign bus.rsp_overflow = ovf_q;
   assign bus.rsp_carryout = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed and random stimulus for alu_arbiter against a
//            behavioural model; honours `define ALU_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(WIDTH)) bus ();
   alu_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   int          m_last;
   bit          m_full;
   bit          m_id;
   logic [31:0] m_res;
   bit          m_z, m_o, m_c;
   bit          m_own, m_own_id;

   // pending request per requester
   bit          pv [2];
   logic [31:0] pa [2];
   logic [31:0] pb [2];
   logic [2:0]  pc [2];
   bit [1:0]    acc;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic ref_alu(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output bit z, output bit o, output bit c);
      longint          sa, sb, sr;
      longint unsigned ua, ub, ur;
      sa = $signed(a); sb = $signed(b); ua = a; ub = b;
      z = 0; o = 0; c = 0; r = 0;
      case (cmd)
         3'd0: begin
            ur = ua + ub; r = ur[31:0]; c = ur[32]; sr = sa + sb;
            o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); z = (r == 0);
         end
         3'd1: begin
            r = a - b; c = (ua >= ub); sr = sa - sb;
            o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); z = (r == 0);
         end
         3'd2: r = a ^ b;
         3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
   endtask

   task automatic model_reset();
      m_last = 1; m_full = 0; m_id = 0; m_res = 0;
      m_z = 0; m_o = 0; m_c = 0; m_own = 0; m_own_id = 0;
   endtask

   // one clock: predict and check ready, advance model, check the slot after the edge
   task automatic step();
      logic [1:0] v, g, exp_rdy;
      bit was_full, gid;
      v = bus.req_valid;
`ifdef ALU_ARB_LOCK_EN
      if (m_own) v = v & (m_own_id ? 2'b10 : 2'b01);
`endif
      g = 2'b00;
      if (v == 2'b01 || v == 2'b10) g = v;
      else if (v == 2'b11) g = (m_last == 0) ? 2'b10 : 2'b01;
      exp_rdy = (!m_full || bus.rsp_ready) ? g : 2'b00;
      #1;
      check_val("req_ready", bus.req_ready, exp_rdy);
      acc = exp_rdy & bus.req_valid;
      was_full = m_full;
      gid = exp_rdy[1];
      if (exp_rdy != 0) begin
         ref_alu(gid ? bus.req_cmd1 : bus.req_cmd0, gid ? bus.req_a1 : bus.req_a0,
                 gid ? bus.req_b1 : bus.req_b0, m_res, m_z, m_o, m_c);
         m_full = 1; m_id = gid; m_last = gid;
`ifdef ALU_ARB_LOCK_EN
         m_own = bus.req_lock[gid]; m_own_id = gid;
`endif
      end else begin
         if (bus.rsp_ready) m_full = 0;
`ifdef ALU_ARB_LOCK_EN
         if (m_own && !bus.req_valid[m_own_id] && !was_full) m_own = 0;
`endif
      end
      @(posedge clk); #1;
      check_val("rsp_valid", bus.rsp_valid, m_full);
      if (m_full) begin
         check_val("rsp_id", bus.rsp_id, m_id);
         check_val("rsp_result", bus.rsp_result, m_res);
         check_val("rsp_flags", {bus.rsp_zero, bus.rsp_overflow, bus.rsp_carryout}, {m_z, m_o, m_c});
      end
   endtask

   task automatic present(input logic [1:0] lk, input logic rr);
      bus.req_valid = {pv[1], pv[0]};
      bus.req_a0 = pa[0]; bus.req_b0 = pb[0]; bus.req_cmd0 = pc[0];
      bus.req_a1 = pa[1]; bus.req_b1 = pb[1]; bus.req_cmd1 = pc[1];
      bus.req_lock = lk;
      bus.rsp_ready = rr;
      step();
      for (int i = 0; i < 2; i++) if (acc[i]) pv[i] = 0;
   endtask

   task automatic load(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      pv[i] = 1; pa[i] = a; pb[i] = b; pc[i] = c;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pv[0] = 0; pv[1] = 0;
      bus.req_valid = 2'b00; bus.req_lock = 2'b00; bus.rsp_ready = 1'b0;
      model_reset();
      #1;
      check_val("rst_rsp_valid", bus.rsp_valid, 0);
      check_val("rst_rsp_id", bus.rsp_id, 0);
      check_val("rst_rsp_result", bus.rsp_result, 0);
      check_val("rst_flags", {bus.rsp_zero, bus.rsp_overflow, bus.rsp_carryout}, 0);
      check_val("rst_req_ready", bus.req_ready, 0);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bus.req_valid = 2'b00; bus.req_lock = 2'b00; bus.rsp_ready = 1'b0;
      bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
      bus.req_cmd0 = '0; bus.req_cmd1 = '0;
      for (int i = 0; i < 2; i++) begin pv[i] = 0; pa[i] = 0; pb[i] = 0; pc[i] = 0; end
      @(posedge clk); #1;
      do_reset();

      // signed overflow on ADD
      load(0, 32'h7FFF_FFFF, 32'h1, 3'd0);
      present(2'b00, 1'b1);
      check_val("add_ovf_id", bus.rsp_id, 0);
      check_val("add_ovf_result", bus.rsp_result, 32'h8000_0000);
      check_val("add_ovf_flags", {bus.rsp_zero, bus.rsp_overflow, bus.rsp_carryout}, 3'b010);
      present(2'b00, 1'b1);

      // both valid every cycle: alternation, last grant was requester 0
      for (int k = 0; k < 4; k++) begin
         if (!pv[0]) load(0, 32'd5, 32'd5, 3'd1);
         if (!pv[1]) load(1, 32'hF0, 32'h0F, 3'd7);
         present(2'b00, 1'b1);
         check_val("alt_id", bus.rsp_id, (k % 2 == 0) ? 1 : 0);
         check_val("alt_result", bus.rsp_result, (k % 2 == 0) ? 32'hFF : 32'h0);
         check_val("alt_zero", bus.rsp_zero, (k % 2 == 0) ? 0 : 1);
      end

      // backpressure: slot held, nobody accepted, then pop+push with no bubble
      if (!pv[0]) load(0, 32'd5, 32'd5, 3'd1);
      for (int k = 0; k < 3; k++) begin
         present(2'b00, 1'b0);
         check_val("bp_hold_id", bus.rsp_id, 0);
         check_val("bp_hold_result", bus.rsp_result, 0);
      end
      present(2'b00, 1'b1);
      check_val("bp_release_id", bus.rsp_id, 1);
      check_val("bp_release_result", bus.rsp_result, 32'hFF);
      present(2'b00, 1'b1);
      present(2'b00, 1'b1);

      // SLT signed and NAND of all ones
      load(1, 32'hFFFF_FFFF, 32'h1, 3'd3);
      load(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5);
      present(2'b00, 1'b1);
      check_val("slt_id", bus.rsp_id, 1);
      check_val("slt_result", bus.rsp_result, 32'h1);
      present(2'b00, 1'b1);
      check_val("nand_id", bus.rsp_id, 0);
      check_val("nand_result", bus.rsp_result, 32'h0);
      check_val("nand_zero", bus.rsp_zero, 0);

      // reset while full, then first tie goes to requester 0
      do_reset();
      load(0, 32'd3, 32'd4, 3'd0);
      load(1, 32'd3, 32'd4, 3'd2);
      present(2'b00, 1'b1);
      check_val("post_rst_tie_id", bus.rsp_id, 0);
      present(2'b00, 1'b1);
      present(2'b00, 1'b1);

      // locked two-op sequence from requester 0 while requester 1 waits
      load(0, 32'hFFFF_FFFF, 32'h1, 3'd0);
      load(1, 32'h12, 32'h21, 3'd7);
      present(2'b01, 1'b1);
      check_val("lock_first_id", bus.rsp_id, 0);
      load(0, 32'h1, 32'h2, 3'd0);
      present(2'b00, 1'b1);
`ifdef ALU_ARB_LOCK_EN
      check_val("lock_second_id", bus.rsp_id, 0);
`else
      check_val("lock_second_id", bus.rsp_id, 1);
`endif
      present(2'b00, 1'b1);
`ifdef ALU_ARB_LOCK_EN
      check_val("lock_third_id", bus.rsp_id, 1);
`else
      check_val("lock_third_id", bus.rsp_id, 0);
`endif
      present(2'b00, 1'b1);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 2; i++)
            if (!pv[i] && $urandom_range(0, 3) != 0)
               load(i, rand_word(), rand_word(), 3'($urandom_range(0, 7)));
         present(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      end
      for (int n = 0; n < 8; n++) present(2'b00, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
